// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the add/sub magnitude comparator pipeline.
// A compare node is an {lt, eq} pair; nodes merge pairwise from MSB-side (hi) to LSB-side (lo).
package add_sub_pkg;

  localparam int CMP_NIB_W = 4;

  typedef enum logic [1:0] {
    CMP_UNSIGNED = 2'b00,
    CMP_SIGNED   = 2'b01,
    CMP_SIGNMAG  = 2'b10
  } cmp_mode_e;

  typedef struct packed {
    logic lt;
    logic eq;
  } cmp_node_t;

  // Neutral element for a missing high node: "equal", so the low node decides.
  localparam cmp_node_t CMP_PAD = '{lt: 1'b0, eq: 1'b1};

  function automatic cmp_node_t cmp_merge(input cmp_node_t hi, input cmp_node_t lo);
    cmp_node_t m;
    m.lt = hi.lt | (hi.eq & lo.lt);
    m.eq = hi.eq & lo.eq;
    return m;
  endfunction

  // Node count after lvl halvings of num_nib leaves (rounded up).
  function automatic int cmp_nodes_at(input int num_nib, input int lvl);
    return (num_nib + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/add_sub_comp_level.sv
// One combine level of the compare tree plus its pipeline register.
// Node 2k+1 is the high half of node 2k; an odd top node is merged with the neutral pad.
module add_sub_comp_level
  import add_sub_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int DATA_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic [N_IN-1:0]           i_lt,
  input  logic [N_IN-1:0]           i_eq,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      o_valid,
  output logic [(N_IN+1)/2-1:0]     o_lt,
  output logic [(N_IN+1)/2-1:0]     o_eq,
  output logic [DATA_W-1:0]         o_data
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT-1:0]  lt_d, eq_d;
  logic [N_OUT-1:0]  lt_q, eq_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_node
    cmp_node_t hi, lo, m;
    assign lo = {i_lt[2*k], i_eq[2*k]};
    if (2*k + 1 < N_IN) begin : g_pair
      assign hi = {i_lt[2*k+1], i_eq[2*k+1]};
    end else begin : g_pad
      assign hi = CMP_PAD;
    end
    assign m       = cmp_merge(hi, lo);
    assign lt_d[k] = m.lt;
    assign eq_d[k] = m.eq;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      lt_q    <= '0;
      eq_q    <= '0;
      data_q  <= '0;
    end else if (i_en) begin
      valid_q <= i_valid;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      data_q  <= i_data;
    end
  end

  assign o_valid = valid_q;
  assign o_lt    = lt_q;
  assign o_eq    = eq_q;
  assign o_data  = data_q;

endmodule

// File: rtl/add_sub_comp_pipe.sv
// Pipelined magnitude comparator: leaf nibble compares, then a registered log2 merge tree.
// Returns less/equal and the original operands reordered as max/min, with a sideband tag.
module add_sub_comp_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic [1:0]       i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_less,
  output logic             o_equal,
  output logic [WIDTH-1:0] o_max,
  output logic [WIDTH-1:0] o_min,
  output logic [TAG_W-1:0] o_tag
);

  localparam int NUM_NIB = WIDTH / CMP_NIB_W;
  localparam int DEPTH   = $clog2(NUM_NIB);
  localparam int DATA_W  = TAG_W + 2 * WIDTH;

  // Handshake: one global enable en = !o_valid | i_ready drives every stage
  // and o_ready. Input transfers on i_valid & o_ready, output on o_valid & i_ready;
  // with en low all stages (valid bits and data) hold, bubbles are not squeezed out.
  logic en;
  assign en      = !o_valid | i_ready;
  assign o_ready = en;

  // Operand pre-processing only feeds the compare; original operands ride the pipe.
  logic [WIDTH-1:0] a_pp, b_pp;
  always_comb begin
    a_pp = i_data_a;
    b_pp = i_data_b;
    case (cmp_mode_e'(i_mode))
      CMP_SIGNED: begin
        a_pp[WIDTH-1] = ~i_data_a[WIDTH-1];
        b_pp[WIDTH-1] = ~i_data_b[WIDTH-1];
      end
      CMP_SIGNMAG: begin
        a_pp[WIDTH-1] = 1'b0;
        b_pp[WIDTH-1] = 1'b0;
      end
      default: ;
    endcase
  end

  logic [NUM_NIB-1:0] leaf_lt_d, leaf_eq_d;
  for (genvar k = 0; k < NUM_NIB; k++) begin : g_leaf
    logic [CMP_NIB_W-1:0] na, nb;
    assign na           = a_pp[k*CMP_NIB_W +: CMP_NIB_W];
    assign nb           = b_pp[k*CMP_NIB_W +: CMP_NIB_W];
    assign leaf_lt_d[k] = (na < nb);
    assign leaf_eq_d[k] = (na == nb);
  end

  // Level 0 is the leaf register; levels 1..DEPTH each halve the node count.
  for (genvar j = 0; j <= DEPTH; j++) begin : g_lvl
    localparam int N = cmp_nodes_at(NUM_NIB, j);
    logic              v_q;
    logic [N-1:0]      lt_q, eq_q;
    logic [DATA_W-1:0] data_q;

    if (j == 0) begin : g_stage0
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v_q    <= 1'b0;
          lt_q   <= '0;
          eq_q   <= '0;
          data_q <= '0;
        end else if (en) begin
          v_q    <= i_valid;
          lt_q   <= leaf_lt_d;
          eq_q   <= leaf_eq_d;
          data_q <= {i_tag, i_data_a, i_data_b};
        end
      end
    end else begin : g_merge
      add_sub_comp_level #(
        .N_IN   (cmp_nodes_at(NUM_NIB, j - 1)),
        .DATA_W (DATA_W)
      ) u_level (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_valid (g_lvl[j-1].v_q),
        .i_lt    (g_lvl[j-1].lt_q),
        .i_eq    (g_lvl[j-1].eq_q),
        .i_data  (g_lvl[j-1].data_q),
        .o_valid (v_q),
        .o_lt    (lt_q),
        .o_eq    (eq_q),
        .o_data  (data_q)
      );
    end
  end

  logic [DATA_W-1:0] out_data;
  logic [WIDTH-1:0]  out_a, out_b;

  assign out_data = g_lvl[DEPTH].data_q;
  assign out_a    = out_data[2*WIDTH-1 -: WIDTH];
  assign out_b    = out_data[WIDTH-1:0];

  assign o_valid  = g_lvl[DEPTH].v_q;
  assign o_less   = g_lvl[DEPTH].lt_q[0];
  assign o_equal  = g_lvl[DEPTH].eq_q[0];
  assign o_tag    = out_data[DATA_W-1 -: TAG_W];
  // Equal operands fall into the "not less" arm: max = A, min = B.
  assign o_max    = o_less ? out_b : out_a;
  assign o_min    = o_less ? out_a : out_b;

endmodule

// File: doc/add_sub_comp_pipe.md
Name: add_sub_comp_pipe

Overview:
- Parametrised, pipelined magnitude comparator for the FPU add/sub datapath.
- Compares two WIDTH-bit operands in unsigned, two's-complement or sign-magnitude mode.
- Returns less/equal flags plus the operands reordered as max/min, so the exponent-alignment stage can use them directly.
- A nibble-compare tree is registered at every level; a valid/ready handshake with global stall and an opaque sideband tag travel with each operand pair.

Parameters:
- WIDTH, 32, operand width in bits; multiple of 4, ≥8.
- TAG_W, 4, sideband tag width carried alongside each operand pair.
- NUM_NIB (derived), WIDTH/4, number of leaf nibble comparators.
- DEPTH (derived), clog2(NUM_NIB), number of combine levels; LATENCY = DEPTH+1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operand pair valid.
- o_ready  out  1  block accepts input this cycle.
- i_data_a  in  WIDTH  operand A.
- i_data_b  in  WIDTH  operand B.
- i_mode  in  2  00 unsigned, 01 two's-complement signed, 10 sign-magnitude, 11 treated as 00.
- i_tag  in  TAG_W  sideband, returned unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_less  out  1  A < B under the selected mode.
- o_equal  out  1  A == B under the selected mode.
- o_max  out  WIDTH  B if o_less, else A (original encoding, not pre-processed).
- o_min  out  WIDTH  A if o_less, else B.
- o_tag  out  TAG_W  tag of this result.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. On reset, all stage valid bits, o_valid, o_less, o_equal, o_max, o_min and o_tag clear to 0.
- Pre-processing is combinational, before the leaf stage:
  - Mode 01: invert the MSB of both operands.
  - Mode 10: force the MSB of both operands to 0, so only magnitudes are compared and +0 equals -0.
  - Original A and B are carried down the pipe unmodified.
- Stage 0 (leaf): each nibble k gives a registered pair {lt_k, eq_k}.
- Combine level j (1..DEPTH): adjacent pairs combine as lt = lt_hi | (eq_hi & lt_lo) and eq = eq_hi & eq_lo, then register.
- Non-power-of-two nibble count: missing high leaves are padded with lt=0, eq=1.
- Output comes from the final level's register. Latency is LATENCY cycles from accepted input to o_valid with no stall; for the defaults, 4.
- Throughput: one pair per cycle.
- Handshake:
  - Global enable en = !o_valid | i_ready; o_ready = en.
  - A transfer in occurs when i_valid & o_ready; a transfer out occurs when o_valid & i_ready.
  - When en=0, every stage, including valid bits and data, holds. Bubbles are not collapsed.
- The output holds stable, with o_valid asserted, until i_ready is seen.
- Mode is sampled with the operands and applies only to that pair. Pairs with different modes may be interleaved back-to-back.
- o_less and o_equal are mutually exclusive. Greater is inferred as !o_less & !o_equal.
- Equal operands: o_max = A, o_min = B.
- i_valid=0 while en=1 inserts a bubble; stage valid clears and data is don't-care but must not toggle o_valid.
- Reset mid-operation: in-flight pairs are discarded and no partial result ever appears.

Decomposition:
- Shared package add_sub_pkg holds:
  - typedef cmp_mode_e (CMP_UNSIGNED, CMP_SIGNED, CMP_SIGNMAG).
  - typedef cmp_node_t struct {lt, eq}.
  - constant CMP_NIB_W = 4.
  - function cmp_merge(hi, lo) returning cmp_node_t.
- Sub-module add_sub_comp_level: one combine level plus its pipeline register, with parameters for input node count and data/tag width. It is generated DEPTH times.

Test Plan:
- WIDTH=32, mode 00, A=0x0000_0001, B=0x8000_0000 -> 4 cycles later: o_less=1, o_equal=0, o_max=0x8000_0000, o_min=0x0000_0001, o_tag echoed.
- Mode 01, same operands -> o_less=0, o_equal=0; o_max=0x0000_0001, o_min=0x8000_0000.
- Mode 10, A=0x8000_0000 (-0), B=0x0000_0000 (+0) -> o_equal=1, o_less=0, o_max=0x8000_0000.
- Stream 8 back-to-back pairs, tags 0..7, with i_ready low on cycles 5-7 -> o_ready low on those cycles, no pair lost or duplicated, results in tag order, outputs held stable while stalled.
- Assert i_rst_n=0 asynchronously with 3 pairs in flight -> o_valid drops immediately; after release the first new pair appears exactly LATENCY cycles after acceptance.
- WIDTH=24 (6 nibbles, padded tree, LATENCY=4): A=0xFFFFFF, B=0xFFFFFE, mode 00 -> o_less=0, o_equal=0; then A=B=0x123456 -> o_equal=1.
